// File: rtl/pll_phase_pkg.sv
// Shared types and helpers for the PLL dynamic phase-shift controller.
package pll_phase_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_WAIT_LO,
        S_WAIT_HI,
        S_NEXT
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_IDX  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_LOCK = 2'd3;

    function automatic int unsigned chunk_min(input int unsigned rem,
                                              input int unsigned cap);
        return (rem < cap) ? rem : cap;
    endfunction

endpackage

// File: rtl/pll_sync2.sv
// Two-flop synchroniser with synchronous active-high reset.
module pll_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pll_phase_shift_ctrl.sv
// Splits signed phase-shift requests into PLL-sized chunks, runs the
// phase_en/phase_done exchange and tracks a per-counter phase position.
module pll_phase_shift_ctrl
    import pll_phase_pkg::*;
#(
    parameter int N_CNT        = 5,
    parameter int CNTSEL_W     = 5,
    parameter int NSHIFT_W     = 3,
    parameter int STEP_W       = 16,
    parameter int ACC_W        = 20,
    parameter int PHASE_EN_CYC = 2,
    parameter int DONE_TIMEOUT = 1023
) (
    input  logic                scanclk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CNTSEL_W-1:0] req_cnt,
    input  logic [STEP_W-1:0]   req_steps,
    input  logic                pll_locked,
    output logic [CNTSEL_W-1:0] cntsel,
    output logic [NSHIFT_W-1:0] num_phase_shifts,
    output logic                updn,
    output logic                phase_en,
    input  logic                phase_done,
    output logic                busy,
    output logic                done_p,
    output logic                err_p,
    output logic [1:0]          err_code,
    input  logic [CNTSEL_W-1:0] pos_sel,
    output logic [ACC_W-1:0]    pos_o
);

    localparam int PW = (PHASE_EN_CYC > 1) ? $clog2(PHASE_EN_CYC) : 1;
    localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam int unsigned CAP = (2 ** NSHIFT_W) - 1;
    localparam logic [CNTSEL_W-1:0] NCNT_L = CNTSEL_W'(N_CNT);

    state_e state_q, state_d;
    logic [CNTSEL_W-1:0] idx_q, idx_d, cntsel_q, cntsel_d;
    logic [NSHIFT_W-1:0] nps_q, nps_d;
    logic dir_q, dir_d, updn_q, updn_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic done_q, done_d, err_q, err_d;
    logic [1:0] code_q, code_d;
    logic acc_en;
    logic pd_s, lk_s;
    logic [ACC_W-1:0] acc_q [N_CNT];

    pll_sync2 u_sync_pd (
        .clk_i (scanclk),
        .rst_i (rst),
        .d_i   (phase_done),
        .q_o   (pd_s)
    );

    pll_sync2 u_sync_lk (
        .clk_i (scanclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (lk_s)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cntsel_d = cntsel_q;
        nps_d    = nps_q;
        dir_d    = dir_q;
        updn_d   = updn_q;
        rem_d    = rem_q;
        pcnt_d   = pcnt_q;
        tmr_d    = tmr_q;
        code_d   = code_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        acc_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_cnt >= NCNT_L) begin
                        err_d  = 1'b1;
                        code_d = ERR_IDX;
                    end else if (req_steps == '0) begin
                        done_d = 1'b1;
                        code_d = ERR_NONE;
                    end else begin
                        idx_d   = req_cnt;
                        dir_d   = ~req_steps[STEP_W-1];
                        rem_d   = req_steps[STEP_W-1]
                                ? (~req_steps + STEP_W'(1)) : req_steps;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                cntsel_d = idx_q;
                updn_d   = dir_q;
                nps_d    = NSHIFT_W'(chunk_min(32'(rem_q), CAP));
                pcnt_d   = '0;
                state_d  = S_PULSE;
            end
            S_PULSE: begin
                if (pcnt_q == PW'(PHASE_EN_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = S_WAIT_LO;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            S_WAIT_LO: begin
                if (!pd_s) begin
                    tmr_d   = '0;
                    state_d = S_WAIT_HI;
                end else if (tmr_q == TW'(DONE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TMO;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_WAIT_HI: begin
                if (pd_s) begin
                    rem_d   = rem_q - STEP_W'(nps_q);
                    acc_en  = 1'b1;
                    state_d = S_NEXT;
                end else if (tmr_q == TW'(DONE_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TMO;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_NEXT: begin
                if (rem_q == '0) begin
                    done_d  = 1'b1;
                    code_d  = ERR_NONE;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Lock loss overrides any in-flight progress, including a completing chunk.
        if (state_q != S_IDLE && !lk_s) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b1;
            code_d  = ERR_LOCK;
            acc_en  = 1'b0;
        end
    end

    always_ff @(posedge scanclk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cntsel_q <= '0;
            nps_q    <= '0;
            dir_q    <= 1'b0;
            updn_q   <= 1'b0;
            rem_q    <= '0;
            pcnt_q   <= '0;
            tmr_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            for (int i = 0; i < N_CNT; i++) acc_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cntsel_q <= cntsel_d;
            nps_q    <= nps_d;
            dir_q    <= dir_d;
            updn_q   <= updn_d;
            rem_q    <= rem_d;
            pcnt_q   <= pcnt_d;
            tmr_q    <= tmr_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
            for (int i = 0; i < N_CNT; i++) begin
                if (acc_en && idx_q == CNTSEL_W'(i)) begin
                    acc_q[i] <= dir_q ? acc_q[i] + ACC_W'(nps_q)
                                      : acc_q[i] - ACC_W'(nps_q);
                end
            end
        end
    end

    always_comb begin
        pos_o = '0;
        for (int i = 0; i < N_CNT; i++) begin
            if (pos_sel == CNTSEL_W'(i)) pos_o = acc_q[i];
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign req_ready        = ~busy;
    assign phase_en         = (state_q == S_PULSE) && lk_s;
    assign cntsel           = cntsel_q;
    assign num_phase_shifts = nps_q;
    assign updn             = updn_q;
    assign done_p           = done_q;
    assign err_p            = err_q;
    assign err_code         = code_q;

endmodule
